op_stream_decoder: RTL and testbench
====================================

OP_STREAM_DECODER -- requirements
Module: op_stream_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255: max idle clocks between bytes of one op before the partial op is discarded.
REQ-002 SHALL have parameter CNT_W, default 16: width of the sample counter.
REQ-003 SHALL have parameter ATTN_W, default 8: width of the attenuation register, 1..8 (low bits of data1).
REQ-004 SHALL have port clk, in, 1: the single clock.
REQ-005 SHALL have port rst, in, 1: synchronous, active-high reset.
REQ-006 SHALL have ports in_byte (in, 8), in_valid (in, 1) and in_ready (out, 1): serial op bytes, MSB byte first.
REQ-007 SHALL have output pulses, 1 bit each: power_on_packet_R1, keyboard_led_update, all_1_packet, mic_start, mic_stop, protocol_error.
REQ-008 SHALL have sample_strobe (out, 1) and sample_data (out, 16): one accepted audio sample, sample_data = {data1,data2}.
REQ-009 SHALL have audio_active, audio_22khz and audio_zero_fill (out, 1 each): latched playback mode.
REQ-010 SHALL have attenuation (out, ATTN_W), sample_count (out, CNT_W) and mic_active (out, 1).

Function
REQ-011 SHALL accept a byte only on a clock where in_valid && in_ready are both high.
REQ-012 SHALL assemble op = {byte0,byte1,byte2} using a 2-bit byte index that wraps to 0 after byte2.
REQ-013 SHALL discard a partial op, return the index to 0 and pulse protocol_error when TIMEOUT_CYCLES consecutive clocks pass with index != 0 and no byte accepted.
REQ-014 SHALL assert all decode pulses and state updates exactly 1 clock after byte2 is accepted; each pulse lasts 1 clock.
REQ-015 SHALL decode ops as follows:
- 0xC5EF__ -> power_on_packet_R1
- 0xC500__ -> keyboard_led_update
- 0xC4xx00 -> attenuation <= data1[ATTN_W-1:0]
- 0xC4 with data2 != 0 -> ignored
- 0xC7____ -> sample
- 0x0B____ -> mic_start
- 0x03____ -> mic_stop
- 0xFF____ -> all_1_packet
REQ-016 SHALL treat a control byte matching 00??1111 as audio start, latching audio_22khz = bit4 and audio_zero_fill = bit5.
REQ-017 SHALL treat a control byte matching 00??0111 as audio end.
REQ-018 SHALL implement an audio FSM with states IDLE and PLAY:
- IDLE + start -> PLAY, sample_count cleared.
- PLAY + start -> stay in PLAY, mode re-latched, count kept.
- PLAY + end -> IDLE, mode bits held.
- IDLE + end -> no change.
REQ-019 SHALL, for a sample in PLAY, pulse sample_strobe with sample_data and increment sample_count, saturating at all-ones.
REQ-020 SHALL, for a sample in IDLE, pulse protocol_error and not assert sample_strobe.
REQ-021 SHALL, on all_1_packet, apply a soft reset the same clock: FSM -> IDLE, mode bits, mic_active and sample_count cleared, attenuation kept; in_ready SHALL then be low for 1 clock.
REQ-022 SHALL drive in_ready high at all other times, including the clock on which decode outputs are asserted.
REQ-023 SHALL hold sample_data at its last value when sample_strobe is low.

Reset
REQ-024 SHALL, while rst is high: force in_ready to 0; clear every pulse output, sample_data, the mode bits, mic_active and sample_count; set the byte index to 0, the timeout counter to 0 and the FSM to IDLE.
REQ-025 SHALL reset attenuation to all-ones (full attenuation).
REQ-026 SHALL, when rst asserts mid-op, discard the partial op without a protocol_error pulse.

Configuration
REQ-027 SHALL, with OPDEC_MIC_EN defined: set mic_active on mic_start and clear it on mic_stop, decoding both ops.
REQ-028 SHALL, without OPDEC_MIC_EN: tie mic_start, mic_stop and mic_active to 0 and ignore ops 0x0B and 0x03, with no protocol_error.

Structure
REQ-029 SHALL define in package op_stream_pkg: opcode constants (0xC5, 0xEF, 0x00, 0xC4, 0xC7, 0x0B, 0x03, 0xFF), the control-byte masks and an audio_state_t enum {IDLE, PLAY}.
REQ-030 SHALL contain one sub-module, op_byte_assembler, implementing byte index, timeout, op register and the op_valid pulse.

Verification
REQ-031 SHALL test: bytes 0x1F,0,0 then 0xC7,0x12,0x34 -> audio_active=1, audio_22khz=1, audio_zero_fill=0; sample_strobe 1 clock after byte2 with sample_data=0x1234, sample_count=1.
REQ-032 SHALL test: 0xC7,0xAA,0xBB while IDLE -> protocol_error pulse, no sample_strobe, sample_count=0.
REQ-033 SHALL test: 0xC4,0x05,0x00 -> attenuation=0x05; then 0xC4,0x07,0x01 -> attenuation stays 0x05.
REQ-034 SHALL test: byte 0xC5, then TIMEOUT_CYCLES idle clocks, then 0xC5,0x00,0x00 -> one protocol_error, then keyboard_led_update only.
REQ-035 SHALL test: in PLAY with sample_count=3, send 0xFF,0xFF,0xFF -> all_1_packet; audio_active=0, sample_count=0; in_ready low for exactly 1 clock.
REQ-036 SHALL test: with OPDEC_MIC_EN, 0x0B,0,0 then 0x03,0,0 -> mic_active rises then falls; without the macro -> mic_active stays 0.

Source files
------------

// File: rtl/op_stream_pkg.sv
// Shared opcodes, control-byte masks and types for the op stream decoder.
package op_stream_pkg;

  localparam int unsigned BYTE_W   = 8;
  localparam int unsigned OP_W     = 24;
  localparam int unsigned SAMPLE_W = 16;

  localparam logic [BYTE_W-1:0] OP_C5 = 8'hC5;
  localparam logic [BYTE_W-1:0] OP_EF = 8'hEF;
  localparam logic [BYTE_W-1:0] OP_00 = 8'h00;
  localparam logic [BYTE_W-1:0] OP_C4 = 8'hC4;
  localparam logic [BYTE_W-1:0] OP_C7 = 8'hC7;
  localparam logic [BYTE_W-1:0] OP_0B = 8'h0B;
  localparam logic [BYTE_W-1:0] OP_03 = 8'h03;
  localparam logic [BYTE_W-1:0] OP_FF = 8'hFF;

  // Bits 5:4 of a control byte carry the playback mode and are don't-care for matching.
  localparam logic [BYTE_W-1:0] CTRL_MASK  = 8'hCF;
  localparam logic [BYTE_W-1:0] CTRL_START = 8'h0F;
  localparam logic [BYTE_W-1:0] CTRL_END   = 8'h07;

  typedef enum logic {
    IDLE = 1'b0,
    PLAY = 1'b1
  } audio_state_t;

  typedef struct packed {
    logic [BYTE_W-1:0] ctrl;
    logic [BYTE_W-1:0] data1;
    logic [BYTE_W-1:0] data2;
  } op_t;

  function automatic logic ctrl_match(input logic [BYTE_W-1:0] b,
                                      input logic [BYTE_W-1:0] pat);
    return (b & CTRL_MASK) == pat;
  endfunction

endpackage

// File: rtl/op_byte_assembler.sv
// Collects three serial bytes into one op; drops a stalled partial op after a timeout.
module op_byte_assembler
  import op_stream_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [BYTE_W-1:0] in_byte,
  input  logic              in_valid,
  input  logic              in_ready,
  output op_t               op_c,
  output logic              op_valid_c,
  output logic              timeout_c
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]        idx_q;
  logic [BYTE_W-1:0] byte0_q;
  logic [BYTE_W-1:0] byte1_q;
  logic [TMO_W-1:0]  tmo_q;
  logic              accept;

  assign accept     = in_valid && in_ready;
  assign op_valid_c = accept && (idx_q == 2'd2);
  assign timeout_c  = !accept && (idx_q != 2'd0) && (tmo_q == TMO_LAST);
  // The last byte is taken straight from the input so decode lands on the next edge.
  assign op_c       = {byte0_q, byte1_q, in_byte};

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= 2'd0;
      byte0_q <= '0;
      byte1_q <= '0;
      tmo_q   <= '0;
    end else if (accept) begin
      tmo_q <= '0;
      case (idx_q)
        2'd0: begin
          byte0_q <= in_byte;
          idx_q   <= 2'd1;
        end
        2'd1: begin
          byte1_q <= in_byte;
          idx_q   <= 2'd2;
        end
        default: idx_q <= 2'd0;
      endcase
    end else if (idx_q != 2'd0) begin
      if (timeout_c) begin
        idx_q <= 2'd0;
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TMO_W'(1);
      end
    end else begin
      tmo_q <= '0;
    end
  end

endmodule

// File: rtl/op_stream_decoder.sv
// Decodes 3-byte ops into control pulses, audio playback state and sample output.
// Optional microphone control is built when OPDEC_MIC_EN is defined.
module op_stream_decoder
  import op_stream_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned ATTN_W         = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   in_byte,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                power_on_packet_R1,
  output logic                keyboard_led_update,
  output logic                all_1_packet,
  output logic                mic_start,
  output logic                mic_stop,
  output logic                protocol_error,
  output logic                sample_strobe,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                audio_active,
  output logic                audio_22khz,
  output logic                audio_zero_fill,
  output logic [ATTN_W-1:0]   attenuation,
  output logic [CNT_W-1:0]    sample_count,
  output logic                mic_active
);

  op_t  op_c;
  logic op_valid_c;
  logic timeout_c;

  op_byte_assembler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_c      (op_c),
    .op_valid_c(op_valid_c),
    .timeout_c (timeout_c)
  );

  audio_state_t        state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                pon_q, pon_d;
  logic                kbd_q, kbd_d;
  logic                all1_q, all1_d;
  logic                perr_q, perr_d;
  logic                strb_q, strb_d;
  logic [SAMPLE_W-1:0] data_q, data_d;
  logic                hz22_q, hz22_d;
  logic                zf_q, zf_d;
  logic [ATTN_W-1:0]   atten_q, atten_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifdef OPDEC_MIC_EN
  logic                mst_q, mst_d;
  logic                msp_q, msp_d;
  logic                mic_q, mic_d;
`endif

  // Next-state and registered-output logic for one decoded op per clock.
  always_comb begin
    state_d    = state_q;
    in_ready_d = !all1_q;
    pon_d      = 1'b0;
    kbd_d      = 1'b0;
    all1_d     = 1'b0;
    perr_d     = timeout_c;
    strb_d     = 1'b0;
    data_d     = data_q;
    hz22_d     = hz22_q;
    zf_d       = zf_q;
    atten_d    = atten_q;
    cnt_d      = cnt_q;
`ifdef OPDEC_MIC_EN
    mst_d      = 1'b0;
    msp_d      = 1'b0;
    mic_d      = mic_q;
`endif
    if (op_valid_c) begin
      if (op_c.ctrl == OP_C5) begin
        if (op_c.data1 == OP_EF)      pon_d = 1'b1;
        else if (op_c.data1 == OP_00) kbd_d = 1'b1;
      end else if (op_c.ctrl == OP_C4) begin
        if (op_c.data2 == OP_00) atten_d = op_c.data1[ATTN_W-1:0];
      end else if (op_c.ctrl == OP_C7) begin
        if (state_q == PLAY) begin
          strb_d = 1'b1;
          data_d = {op_c.data1, op_c.data2};
          if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
        end else begin
          perr_d = 1'b1;
        end
      end else if (op_c.ctrl == OP_FF) begin
        // Soft reset: everything but attenuation returns to idle defaults.
        all1_d  = 1'b1;
        state_d = IDLE;
        hz22_d  = 1'b0;
        zf_d    = 1'b0;
        cnt_d   = '0;
`ifdef OPDEC_MIC_EN
        mic_d   = 1'b0;
`endif
      end else if (ctrl_match(op_c.ctrl, CTRL_START)) begin
        hz22_d  = op_c.ctrl[4];
        zf_d    = op_c.ctrl[5];
        state_d = PLAY;
        if (state_q == IDLE) cnt_d = '0;
      end else if (ctrl_match(op_c.ctrl, CTRL_END)) begin
        state_d = IDLE;
`ifdef OPDEC_MIC_EN
      end else if (op_c.ctrl == OP_0B) begin
        mst_d = 1'b1;
        mic_d = 1'b1;
      end else if (op_c.ctrl == OP_03) begin
        msp_d = 1'b1;
        mic_d = 1'b0;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      in_ready_q <= 1'b0;
      pon_q      <= 1'b0;
      kbd_q      <= 1'b0;
      all1_q     <= 1'b0;
      perr_q     <= 1'b0;
      strb_q     <= 1'b0;
      data_q     <= '0;
      hz22_q     <= 1'b0;
      zf_q       <= 1'b0;
      atten_q    <= '1;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      pon_q      <= pon_d;
      kbd_q      <= kbd_d;
      all1_q     <= all1_d;
      perr_q     <= perr_d;
      strb_q     <= strb_d;
      data_q     <= data_d;
      hz22_q     <= hz22_d;
      zf_q       <= zf_d;
      atten_q    <= atten_d;
      cnt_q      <= cnt_d;
    end
  end

`ifdef OPDEC_MIC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_q <= 1'b0;
      msp_q <= 1'b0;
      mic_q <= 1'b0;
    end else begin
      mst_q <= mst_d;
      msp_q <= msp_d;
      mic_q <= mic_d;
    end
  end

  assign mic_start  = mst_q;
  assign mic_stop   = msp_q;
  assign mic_active = mic_q;
`else
  assign mic_start  = 1'b0;
  assign mic_stop   = 1'b0;
  assign mic_active = 1'b0;
`endif

  assign in_ready            = in_ready_q;
  assign power_on_packet_R1  = pon_q;
  assign keyboard_led_update = kbd_q;
  assign all_1_packet        = all1_q;
  assign protocol_error      = perr_q;
  assign sample_strobe       = strb_q;
  assign sample_data         = data_q;
  assign audio_active        = (state_q == PLAY);
  assign audio_22khz         = hz22_q;
  assign audio_zero_fill     = zf_q;
  assign attenuation         = atten_q;
  assign sample_count        = cnt_q;

endmodule

// File: tb/tb_op_stream_decoder.sv
// Directed, table-driven bench for op_stream_decoder (mic checks follow OPDEC_MIC_EN).
module tb_op_stream_decoder;

  localparam int unsigned T = 255;
`ifdef OPDEC_MIC_EN
  localparam bit MIC = 1'b1;
`else
  localparam bit MIC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_byte;
  logic        in_valid;
  logic        in_ready;
  logic        power_on_packet_R1, keyboard_led_update, all_1_packet;
  logic        mic_start, mic_stop, protocol_error, sample_strobe;
  logic [15:0] sample_data;
  logic        audio_active, audio_22khz, audio_zero_fill;
  logic [7:0]  attenuation;
  logic [15:0] sample_count;
  logic        mic_active;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  op_stream_decoder dut (
    .clk                (clk),
    .rst                (rst),
    .in_byte            (in_byte),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .power_on_packet_R1 (power_on_packet_R1),
    .keyboard_led_update(keyboard_led_update),
    .all_1_packet       (all_1_packet),
    .mic_start          (mic_start),
    .mic_stop           (mic_stop),
    .protocol_error     (protocol_error),
    .sample_strobe      (sample_strobe),
    .sample_data        (sample_data),
    .audio_active       (audio_active),
    .audio_22khz        (audio_22khz),
    .audio_zero_fill    (audio_zero_fill),
    .attenuation        (attenuation),
    .sample_count       (sample_count),
    .mic_active         (mic_active)
  );

  // {power_on, kbd_led, all_1, mic_start, mic_stop, protocol_error, sample_strobe}
  logic [6:0] pulses;
  assign pulses = {power_on_packet_R1, keyboard_led_update, all_1_packet,
                   mic_start, mic_stop, protocol_error, sample_strobe};
  localparam logic [6:0] PMASK = MIC ? 7'h7F : 7'b1110011;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [6:0]  p;
    logic [2:0]  st;    // {audio_active, audio_22khz, audio_zero_fill}
    logic [15:0] data;
    logic [7:0]  atten;
    logic [15:0] cnt;
    logic        mic;
  } vec_t;

  vec_t vt[18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    if (!in_ready) begin
      in_valid = 1'b0;
      while (!in_ready && n < 8) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready) chk("in_ready_wait", 32'(in_ready), 32'd1);
    end
    in_byte  = b;
    in_valid = 1'b1;
  endtask

  // Leaves the caller at the negedge right after the edge that took byte2.
  task automatic send_op(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
    put(b0);
    put(b1);
    put(b2);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] last_data;
    int nerr, at;

    vt[0]  = '{8'hC7, 8'hAA, 8'hBB, 7'b0000010, 3'b000, 16'h0000, 8'hFF, 16'd0, 1'b0};
    vt[1]  = '{8'hC4, 8'h05, 8'h00, 7'b0000000, 3'b000, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[2]  = '{8'hC4, 8'h07, 8'h01, 7'b0000000, 3'b000, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[3]  = '{8'hC5, 8'hEF, 8'h00, 7'b1000000, 3'b000, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[4]  = '{8'hC5, 8'h00, 8'h12, 7'b0100000, 3'b000, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[5]  = '{8'h1F, 8'h00, 8'h00, 7'b0000000, 3'b110, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[6]  = '{8'hC7, 8'h12, 8'h34, 7'b0000001, 3'b110, 16'h1234, 8'h05, 16'd1, 1'b0};
    vt[7]  = '{8'h2F, 8'h00, 8'h00, 7'b0000000, 3'b101, 16'h0000, 8'h05, 16'd1, 1'b0};
    vt[8]  = '{8'hC7, 8'h56, 8'h78, 7'b0000001, 3'b101, 16'h5678, 8'h05, 16'd2, 1'b0};
    vt[9]  = '{8'h27, 8'h00, 8'h00, 7'b0000000, 3'b001, 16'h0000, 8'h05, 16'd2, 1'b0};
    vt[10] = '{8'h07, 8'h00, 8'h00, 7'b0000000, 3'b001, 16'h0000, 8'h05, 16'd2, 1'b0};
    vt[11] = '{8'hC7, 8'h00, 8'h01, 7'b0000010, 3'b001, 16'h0000, 8'h05, 16'd2, 1'b0};
    vt[12] = '{8'h0B, 8'h00, 8'h00, 7'b0001000, 3'b001, 16'h0000, 8'h05, 16'd2, 1'b1};
    vt[13] = '{8'h03, 8'h00, 8'h00, 7'b0000100, 3'b001, 16'h0000, 8'h05, 16'd2, 1'b0};
    vt[14] = '{8'h0F, 8'h00, 8'h00, 7'b0000000, 3'b100, 16'h0000, 8'h05, 16'd0, 1'b0};
    vt[15] = '{8'hC7, 8'h01, 8'h02, 7'b0000001, 3'b100, 16'h0102, 8'h05, 16'd1, 1'b0};
    vt[16] = '{8'hC7, 8'h03, 8'h04, 7'b0000001, 3'b100, 16'h0304, 8'h05, 16'd2, 1'b0};
    vt[17] = '{8'hC7, 8'h05, 8'h06, 7'b0000001, 3'b100, 16'h0506, 8'h05, 16'd3, 1'b0};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_pulses", 32'(pulses), 32'd0);
    chk("rst_atten", 32'(attenuation), 32'hFF);
    chk("rst_count", 32'(sample_count), 32'd0);
    chk("rst_state", 32'({audio_active, audio_22khz, audio_zero_fill, mic_active}), 32'd0);
    chk("rst_data", 32'(sample_data), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    last_data = 16'h0000;
    for (int i = 0; i < 18; i++) begin
      send_op(vt[i].b0, vt[i].b1, vt[i].b2);
      if (vt[i].p[0]) last_data = vt[i].data;
      chk($sformatf("v%0d_pulses", i), 32'(pulses), 32'(vt[i].p & PMASK));
      chk($sformatf("v%0d_state", i), 32'({audio_active, audio_22khz, audio_zero_fill}), 32'(vt[i].st));
      chk($sformatf("v%0d_atten", i), 32'(attenuation), 32'(vt[i].atten));
      chk($sformatf("v%0d_count", i), 32'(sample_count), 32'(vt[i].cnt));
      chk($sformatf("v%0d_data", i), 32'(sample_data), 32'(last_data));
      chk($sformatf("v%0d_mic", i), 32'(mic_active), 32'(vt[i].mic & MIC));
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      @(negedge clk);
      chk($sformatf("v%0d_pulse_clear", i), 32'(pulses), 32'd0);
    end

    // One clock short of the timeout: the op must survive.
    put(8'hC5);
    nerr = 0;
    for (int i = 1; i <= int'(T) - 1; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (protocol_error) nerr++;
    end
    put(8'h00);
    put(8'h00);
    @(negedge clk);
    in_valid = 1'b0;
    chk("tmo_short_err", 32'(nerr), 32'd0);
    chk("tmo_short_pulses", 32'(pulses), 32'b0100000);

    // Exactly the timeout: one error, then a fresh op decodes cleanly.
    put(8'hC5);
    nerr = 0;
    at = 0;
    for (int i = 1; i <= int'(T) + 1; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (protocol_error) begin
        nerr++;
        at = i;
      end
    end
    chk("tmo_err_count", 32'(nerr), 32'd1);
    chk("tmo_err_cycle", 32'(at), 32'(T + 1));
    send_op(8'hC5, 8'h00, 8'h00);
    chk("tmo_after_pulses", 32'(pulses), 32'b0100000);

    // Soft reset from PLAY with three samples counted.
    send_op(8'h0B, 8'h00, 8'h00);
    chk("pre_ff_count", 32'(sample_count), 32'd3);
    chk("pre_ff_active", 32'(audio_active), 32'd1);
    chk("pre_ff_mic", 32'(mic_active), 32'(MIC));
    send_op(8'hFF, 8'hFF, 8'hFF);
    chk("ff_pulses", 32'(pulses), 32'b0010000);
    chk("ff_state", 32'({audio_active, audio_22khz, audio_zero_fill, mic_active}), 32'd0);
    chk("ff_count", 32'(sample_count), 32'd0);
    chk("ff_atten", 32'(attenuation), 32'h05);
    chk("ff_in_ready_decode", 32'(in_ready), 32'd1);
    @(negedge clk);
    chk("ff_in_ready_low", 32'(in_ready), 32'd0);
    chk("ff_pulse_clear", 32'(pulses), 32'd0);
    @(negedge clk);
    chk("ff_in_ready_back", 32'(in_ready), 32'd1);

    // Reset in the middle of an op discards it silently.
    put(8'hC5);
    put(8'hEF);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    nerr = 0;
    repeat (2) begin
      @(negedge clk);
      if (protocol_error) nerr++;
    end
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_atten", 32'(attenuation), 32'hFF);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (protocol_error) nerr++;
    end
    chk("midrst_no_err", 32'(nerr), 32'd0);
    send_op(8'hC5, 8'h00, 8'h00);
    chk("midrst_fresh_op", 32'(pulses), 32'b0100000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
